// File: rtl/pending_encoder8x3.sv
// pending_encoder8x3: sticky 8-event pending register served one at a time as a 3-bit code over valid/ready in fixed priority (clk_in, rst_in, req_in, ready_in -> valid_out, code_out, pending_out, overflow_out); define PENC_BYPASS_EN to let req_in feed the slot directly
module pending_encoder8x3 #(
  parameter bit PRIO_HIGH = 1'b1
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] req_in,
  input  logic       ready_in,
  output logic       valid_out,
  output logic [2:0] code_out,
  output logic [7:0] pending_out,
  output logic       overflow_out
);
  logic [7:0] cand, load, p_next;
  logic [2:0] idx;
  logic       slot_free;
  assign slot_free = !valid_out || ready_in;
`ifdef PENC_BYPASS_EN
  assign cand = pending_out | req_in;
`else
  assign cand = pending_out;
`endif
  always_comb begin
    idx = '0;
    for (int i = 0; i < 8; i++)
      if (cand[3'(PRIO_HIGH ? i : 7 - i)]) idx = 3'(PRIO_HIGH ? i : 7 - i);
  end
  assign load = (slot_free && |cand) ? 8'b1 << idx : '0;
  assign p_next = (pending_out & ~load) | (req_in & ~(load & ~pending_out));
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      pending_out  <= '0;
      valid_out    <= 1'b0;
      code_out     <= '0;
      overflow_out <= 1'b0;
    end else begin
      pending_out  <= p_next;
      overflow_out <= overflow_out || |(req_in & pending_out & ~load);
      if (slot_free) valid_out <= |cand;
      if (slot_free && |cand) code_out <= idx;
    end
  end
endmodule

// File: doc/pending_encoder8x3.md
# pending_encoder8x3

Sequential 8-to-3 event encoder: the inverse of the team's 3-to-8 decoder. Eight independent request lines post events into a sticky pending register; the block emits them one at a time as a 3-bit index code over a valid/ready handshake, in fixed priority order. It sits between scattered event sources and any consumer that drives a decoder3x8 or indexes a table by code.

## Interface
- PRIO_HIGH, default 1: 1 = bit 7 highest priority; 0 = bit 0 highest priority.
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  reset; synchronous and active-high.
- req_in  input  8  event pulses; bit k high in a cycle posts event k.
- ready_in  input  1  consumer accepts code_out this cycle.
- valid_out  output  1  code_out holds a valid event index.
- code_out  output  3  binary index k of the presented event.
- pending_out  output  8  current pending register P (not yet presented).
- overflow_out  output  1  sticky: an event was merged into an already-pending bit.

## Operation
- State: pending register P[7:0]; output slot (valid_out, code_out); overflow flag.
- Slot states: EMPTY (valid_out=0), FULL (valid_out=1).
- Accept = valid_out & ready_in. Slot free = !valid_out | ready_in.
- Candidate set C = P (or P | req_in with bypass, see Configuration).
- Load: if slot free and C != 0, slot <= FULL, code_out <= priority index of C, load one-hot L = that bit; else L = 0.
- If slot free and C == 0: slot <= EMPTY; code_out holds its last value.
- If FULL and !ready_in: valid_out and code_out hold unchanged (no retraction, no code change).
- P_next = (P & ~L) | req_in (with bypass, a bit loaded directly from req_in is not set in P).
- Overflow: set when any k has req_in[k] & P[k] & ~L[k]. Merged events are lost (count not kept). Cleared only by reset.
- req_in[k] while code k sits in the slot: not overflow; event k re-enters P.
- req_in[k] in the same cycle P[k] is loaded: not overflow; P[k] stays 1.
- Multiple simultaneous req_in bits: all set in P; served strictly by priority.
- Starvation of low-priority bits under continuous high-priority traffic is permitted.

## Timing
- Reset (rst_in high at an edge): P=0, valid_out=0, code_out=0, overflow_out=0, pending_out=0; any in-flight slot contents discarded; req_in in the reset cycle ignored.
- Latency without bypass: req_in at cycle n with slot EMPTY -> P set after edge n -> valid_out high from cycle n+2.
- Throughput: one code per cycle while ready_in stays high and P != 0 (back-to-back accept + load).
- pending_out reflects the register P (registered, not combinational).
- All outputs are registered; no combinational path from inputs to outputs.

## Configuration
- PENC_BYPASS_EN defined: C = P | req_in; an event arriving into an EMPTY or accepting slot can be presented from cycle n+1. Overflow and priority rules unchanged; the loaded bit is cleared regardless of source.
- PENC_BYPASS_EN undefined: C = P only; minimum latency 2 cycles as above.

## Test plan
- Reset: drive req_in=8'hFF, ready_in=0, assert rst_in one cycle -> all outputs 0 next cycle; no events retained.
- Single event, no bypass: req_in=8'h20 one cycle, ready_in=1 -> valid_out=1, code_out=3'd5 two cycles later for exactly one cycle; pending_out returns to 0.
- Priority drain (PRIO_HIGH=1): req_in=8'b1001_0010 one cycle, ready_in=1 -> codes 7,4,1 on three consecutive cycles, then valid_out=0; repeat with PRIO_HIGH=0 -> 1,4,7.
- Back-pressure: code 3 presented, ready_in=0 for 5 cycles while req_in=8'h80 pulses -> code_out stays 3, valid_out stays 1; after ready_in=1, code 7 follows next cycle.
- Overflow: req_in=8'h04 at cycle 0 and again at cycle 1 with ready_in=0 and slot FULL on another code -> overflow_out=1 from cycle 2, stays 1 until reset; event 2 presented once.
- Bypass (PENC_BYPASS_EN defined): idle block, req_in=8'h01 at cycle n -> valid_out=1, code_out=0 at cycle n+1; P[0] never set.
